register_file_32x32: RTL and testbench
======================================

Name: register_file_32x32

Overview:
- General-purpose register file: 32 entries x 32 bits, one synchronous write port, two independent read ports.
- Sits in the core datapath between decode (read operands) and writeback (write result).
- Reads are combinational and gated by per-port enables; writes commit on the rising clock edge.

Parameters:
- DATA_WIDTH, 32, width of each register and of the wdata/rdata buses.
- ADDR_WIDTH, 5, width of each address bus.
- DEPTH, 2**ADDR_WIDTH (32), number of registers.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-high reset (1 = reset, sampled on the rising edge of clk).
- read_en  input  2  per-port read enable; bit 0 enables port 0, bit 1 enables port 1.
- write_en  input  1  write enable.
- raddr_0  input  ADDR_WIDTH  read address, port 0.
- raddr_1  input  ADDR_WIDTH  read address, port 1.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  DATA_WIDTH  write data.
- rdata_0  output  DATA_WIDTH  read data, port 0.
- rdata_1  output  DATA_WIDTH  read data, port 1.

Behaviour:
- Storage: DEPTH x DATA_WIDTH flops.
  - All entries, including address 0, are fully writable and readable.
  - No hardwired-zero register.
- Reset: on a rising edge of clk with reset_n=1, every entry clears to 0.
  - Reset has priority over a simultaneous write; the write is dropped.
  - Asserting reset mid-sequence discards all prior contents.
- Write:
  - On a rising edge of clk with reset_n=0 and write_en=1, mem[waddr] <= wdata.
  - Visible on the read ports immediately after that edge.
  - write_en=0 leaves all entries unchanged.
- Read port k (k = 0, 1), purely combinational (zero-cycle latency):
  - rdata_k = read_en[k] ? mem[raddr_k] : 0.
  - Output follows address/enable changes within the same cycle.
- Ports are independent:
  - Both may read the same or different addresses concurrently.
  - A disabled port drives 0 regardless of its address.
- Read/write collision (same address, same cycle, before the edge): read returns the old contents. No write-to-read bypass.
  - New data appears after the rising edge.
- Output values during and immediately after reset: 0 (entries cleared; disabled ports also drive 0).
- Addresses are full-range; no out-of-range case exists.
- X on a disabled port's address must not propagate to its output.

Decomposition:
- Shared package regfile_pkg: DATA_WIDTH, ADDR_WIDTH, DEPTH constants; typedefs reg_addr_t (logic [ADDR_WIDTH-1:0]) and reg_data_t (logic [DATA_WIDTH-1:0]).
- One natural sub-module: register_file_read_port (enable-gated DEPTH:1 mux, instantiated twice).
- Storage and write decode stay in the top module.

Test Plan:
- Reset: write 0xDEADBEEF to reg 7, assert reset_n=1 for one edge, read reg 7 on both ports with read_en=2'b11 -> both rdata = 0x00000000.
- Walking fill per register: for each address 0..31, write 0x00000001, 0x00000003, ... up to 0xFFFFFFFF, then shift in zeros (0xFFFFFFFE ... 0x00000000).
  - After each write, read port 0 only (read_en=01), then port 1 only (10), then both (11).
  - Each enabled port must equal the last written value; register 0 included.
- Enable gating: reg 5 = 0x12345678, raddr_0=raddr_1=5.
  - read_en=01 -> rdata_0=0x12345678, rdata_1=0.
  - read_en=10 -> rdata_0=0, rdata_1=0x12345678.
  - read_en=00 -> both 0.
- Independent ports: reg 3=0xAAAA5555, reg 30=0x0F0F0F0F, raddr_0=3, raddr_1=30, read_en=11 -> rdata_0=0xAAAA5555, rdata_1=0x0F0F0F0F.
  - Changing raddr_0 to 30 mid-cycle -> rdata_0=0x0F0F0F0F within the same cycle.
- Write/read collision and write_en=0:
  - reg 9=0x1, then in one cycle write 0x2 to reg 9 while reading reg 9 -> rdata=0x1 before the edge, 0x2 after.
  - A cycle with write_en=0, waddr=9, wdata=0x3 -> reg 9 stays 0x2.
- Reset vs write priority: reset_n=1 and write_en=1 (waddr=4, wdata=0xFFFFFFFF) on the same edge -> reg 4 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing constants, storage types and the address decoder used by the
// 32x32 general-purpose register file.
package regfile_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int DEPTH      = 2 ** ADDR_WIDTH;

   typedef logic [ADDR_WIDTH-1:0]             reg_addr_t;
   typedef logic [DATA_WIDTH-1:0]             reg_data_t;
   typedef logic [DEPTH-1:0]                  reg_sel_t;
   typedef logic [DEPTH-1:0][DATA_WIDTH-1:0]  reg_array_t;

   // One-hot select for an entry; an unknown address selects nothing.
   function automatic reg_sel_t addr_decode(input reg_addr_t addr);
      reg_sel_t sel;
      sel       = '0;
      sel[addr] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/register_file_read_port.sv
// Enable-gated DEPTH:1 combinational read mux; a disabled port drives zero
// regardless of its address.
module register_file_read_port
   import regfile_pkg::*;
(
   input  logic       en,
   input  reg_addr_t  addr,
   input  reg_array_t mem,
   output reg_data_t  rdata
);

   reg_sel_t sel_s;

   // Gate the decoded select with the enable so the address cannot leak through.
   always_comb begin
      sel_s = '0;
      if (en) begin
         sel_s = addr_decode(addr);
      end else begin
         sel_s = '0;
      end
   end

   // AND-OR mux over all entries.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rdata = rdata | (mem[i] & {DATA_WIDTH{sel_s[i]}});
      end
   end

endmodule

// File: rtl/register_file_32x32.sv
// 32 x 32 register file: one synchronous write port, two combinational
// enable-gated read ports, synchronous active-high clear on reset_n.
module register_file_32x32
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] read_en,
   input  logic       write_en,
   input  reg_addr_t  raddr_0,
   input  reg_addr_t  raddr_1,
   input  reg_addr_t  waddr,
   input  reg_data_t  wdata,
   output reg_data_t  rdata_0,
   output reg_data_t  rdata_1
);

   reg_array_t mem_r;
   reg_sel_t   wsel_s;

   // Write decode: one-hot entry select, empty when no write is requested.
   always_comb begin
      wsel_s = '0;
      if (write_en) begin
         wsel_s = addr_decode(waddr);
      end else begin
         wsel_s = '0;
      end
   end

   // Storage; reset_n is active-high here and wins over a coincident write.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         mem_r <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wsel_s[i]) begin
               mem_r[i] <= wdata;
            end
         end
      end
   end

   // Reads see the current storage only, so a same-cycle write is not bypassed.
   register_file_read_port u_read_port_0 (
      .en    (read_en[0]),
      .addr  (raddr_0),
      .mem   (mem_r),
      .rdata (rdata_0)
   );

   register_file_read_port u_read_port_1 (
      .en    (read_en[1]),
      .addr  (raddr_1),
      .mem   (mem_r),
      .rdata (rdata_1)
   );

endmodule

// File: tb/tb_register_file_32x32.sv
// Directed self-checking bench for register_file_32x32: one task per scenario,
// inputs changed 1 time unit after the rising edge, outputs sampled before the next.
module tb_register_file_32x32;
   import regfile_pkg::*;

   logic       clk;
   logic       reset_n;
   logic [1:0] read_en;
   logic       write_en;
   reg_addr_t  raddr_0;
   reg_addr_t  raddr_1;
   reg_addr_t  waddr;
   reg_data_t  wdata;
   reg_data_t  rdata_0;
   reg_data_t  rdata_1;

   int total;
   int bad;

   register_file_32x32 dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .read_en  (read_en),
      .write_en (write_en),
      .raddr_0  (raddr_0),
      .raddr_1  (raddr_1),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata_0  (rdata_0),
      .rdata_1  (rdata_1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic write_reg(input reg_addr_t a, input reg_data_t d);
      waddr    = a;
      wdata    = d;
      write_en = 1'b1;
      @(posedge clk);
      #1;
      write_en = 1'b0;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
   endtask

   task automatic test_reset();
      pulse_reset();
      read_en = 2'b11;
      for (int a = 0; a < DEPTH; a++) begin
         raddr_0 = reg_addr_t'(a);
         raddr_1 = reg_addr_t'(DEPTH - 1 - a);
         #1;
         total++;
         if (rdata_0 !== 32'h0000_0000) begin
            bad++;
            $display("FAIL reset_clear_p0 addr=%0d got=%h exp=%h", a, rdata_0, 32'h0);
         end
         total++;
         if (rdata_1 !== 32'h0000_0000) begin
            bad++;
            $display("FAIL reset_clear_p1 addr=%0d got=%h exp=%h", DEPTH - 1 - a, rdata_1, 32'h0);
         end
      end
      write_reg(5'd7, 32'hDEAD_BEEF);
      raddr_0 = 5'd7;
      raddr_1 = 5'd7;
      #1;
      total++;
      if (rdata_0 !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL reset_prewrite got=%h exp=%h", rdata_0, 32'hDEAD_BEEF);
      end
      pulse_reset();
      total++;
      if (rdata_0 !== 32'h0000_0000) begin
         bad++;
         $display("FAIL reset_r7_p0 got=%h exp=%h", rdata_0, 32'h0);
      end
      total++;
      if (rdata_1 !== 32'h0000_0000) begin
         bad++;
         $display("FAIL reset_r7_p1 got=%h exp=%h", rdata_1, 32'h0);
      end
   endtask

   task automatic test_walking_fill();
      reg_data_t v;
      for (int a = 0; a < DEPTH; a++) begin
         v = 32'h0000_0000;
         for (int step = 0; step < 64; step++) begin
            if (step < 32) v = {v[30:0], 1'b1};
            else           v = {v[30:0], 1'b0};
            write_reg(reg_addr_t'(a), v);
            raddr_0 = reg_addr_t'(a);
            raddr_1 = reg_addr_t'(a);
            read_en = 2'b01;
            #1;
            total++;
            if (rdata_0 !== v || rdata_1 !== 32'h0000_0000) begin
               bad++;
               $display("FAIL walk_en01 addr=%0d got0=%h got1=%h exp0=%h exp1=%h",
                        a, rdata_0, rdata_1, v, 32'h0);
            end
            read_en = 2'b10;
            #1;
            total++;
            if (rdata_0 !== 32'h0000_0000 || rdata_1 !== v) begin
               bad++;
               $display("FAIL walk_en10 addr=%0d got0=%h got1=%h exp0=%h exp1=%h",
                        a, rdata_0, rdata_1, 32'h0, v);
            end
            read_en = 2'b11;
            #1;
            total++;
            if (rdata_0 !== v || rdata_1 !== v) begin
               bad++;
               $display("FAIL walk_en11 addr=%0d got0=%h got1=%h exp=%h",
                        a, rdata_0, rdata_1, v);
            end
         end
      end
   endtask

   task automatic test_enable_gating();
      write_reg(5'd5, 32'h1234_5678);
      raddr_0 = 5'd5;
      raddr_1 = 5'd5;
      read_en = 2'b01;
      #1;
      total++;
      if (rdata_0 !== 32'h1234_5678 || rdata_1 !== 32'h0000_0000) begin
         bad++;
         $display("FAIL gate_en01 got0=%h got1=%h exp0=%h exp1=%h", rdata_0, rdata_1, 32'h1234_5678, 32'h0);
      end
      read_en = 2'b10;
      #1;
      total++;
      if (rdata_0 !== 32'h0000_0000 || rdata_1 !== 32'h1234_5678) begin
         bad++;
         $display("FAIL gate_en10 got0=%h got1=%h exp0=%h exp1=%h", rdata_0, rdata_1, 32'h0, 32'h1234_5678);
      end
      read_en = 2'b00;
      #1;
      total++;
      if (rdata_0 !== 32'h0000_0000 || rdata_1 !== 32'h0000_0000) begin
         bad++;
         $display("FAIL gate_en00 got0=%h got1=%h exp=%h", rdata_0, rdata_1, 32'h0);
      end
      raddr_0 = 'x;
      raddr_1 = 'x;
      #1;
      total++;
      if (rdata_0 !== 32'h0000_0000 || rdata_1 !== 32'h0000_0000) begin
         bad++;
         $display("FAIL gate_xaddr got0=%h got1=%h exp=%h", rdata_0, rdata_1, 32'h0);
      end
   endtask

   task automatic test_independent_ports();
      write_reg(5'd3, 32'hAAAA_5555);
      write_reg(5'd30, 32'h0F0F_0F0F);
      raddr_0 = 5'd3;
      raddr_1 = 5'd30;
      read_en = 2'b11;
      #1;
      total++;
      if (rdata_0 !== 32'hAAAA_5555 || rdata_1 !== 32'h0F0F_0F0F) begin
         bad++;
         $display("FAIL indep_read got0=%h got1=%h exp0=%h exp1=%h", rdata_0, rdata_1, 32'hAAAA_5555, 32'h0F0F_0F0F);
      end
      raddr_0 = 5'd30;
      #1;
      total++;
      if (rdata_0 !== 32'h0F0F_0F0F) begin
         bad++;
         $display("FAIL indep_addr_change got=%h exp=%h", rdata_0, 32'h0F0F_0F0F);
      end
   endtask

   task automatic test_collision();
      write_reg(5'd9, 32'h0000_0001);
      raddr_0  = 5'd9;
      raddr_1  = 5'd9;
      read_en  = 2'b11;
      waddr    = 5'd9;
      wdata    = 32'h0000_0002;
      write_en = 1'b1;
      #1;
      total++;
      if (rdata_0 !== 32'h0000_0001 || rdata_1 !== 32'h0000_0001) begin
         bad++;
         $display("FAIL collide_before got0=%h got1=%h exp=%h", rdata_0, rdata_1, 32'h1);
      end
      @(posedge clk);
      #1;
      write_en = 1'b0;
      total++;
      if (rdata_0 !== 32'h0000_0002 || rdata_1 !== 32'h0000_0002) begin
         bad++;
         $display("FAIL collide_after got0=%h got1=%h exp=%h", rdata_0, rdata_1, 32'h2);
      end
      waddr = 5'd9;
      wdata = 32'h0000_0003;
      @(posedge clk);
      #1;
      total++;
      if (rdata_0 !== 32'h0000_0002) begin
         bad++;
         $display("FAIL write_en_low got=%h exp=%h", rdata_0, 32'h2);
      end
   endtask

   task automatic test_reset_priority();
      write_reg(5'd4, 32'h5A5A_5A5A);
      raddr_0  = 5'd4;
      raddr_1  = 5'd9;
      read_en  = 2'b11;
      waddr    = 5'd4;
      wdata    = 32'hFFFF_FFFF;
      write_en = 1'b1;
      reset_n  = 1'b1;
      @(posedge clk);
      #1;
      write_en = 1'b0;
      reset_n  = 1'b0;
      total++;
      if (rdata_0 !== 32'h0000_0000) begin
         bad++;
         $display("FAIL reset_prio_r4 got=%h exp=%h", rdata_0, 32'h0);
      end
      total++;
      if (rdata_1 !== 32'h0000_0000) begin
         bad++;
         $display("FAIL reset_prio_r9 got=%h exp=%h", rdata_1, 32'h0);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      reset_n  = 1'b0;
      read_en  = 2'b00;
      write_en = 1'b0;
      raddr_0  = 5'd0;
      raddr_1  = 5'd0;
      waddr    = 5'd0;
      wdata    = 32'h0000_0000;
      @(posedge clk);
      #1;
      test_reset();
      test_walking_fill();
      test_enable_gating();
      test_independent_ports();
      test_collision();
      test_reset_priority();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
